mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 109 ++++++++++
 tb/tb_mem_port_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-master (inst/data) arbiter onto one SRAM-like port, with an in-order
// source FIFO that steers each mem_data_ok back to the side that issued it.
module mem_port_arbiter #(
  parameter int MAX_OUTST = 2
) (
  input  logic        clk,
  input  logic        resetn,
  // instruction side
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  // data side
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  // shared memory port
  output logic        mem_req,
  output logic        mem_wr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic [2:0]  outst_cnt
);

  localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

  typedef enum logic {SRC_INST = 1'b0, SRC_DATA = 1'b1} src_e;

  src_e             src_fifo [MAX_OUTST];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             lock_vld;
  src_e             lock_src;
  src_e             grant;
  src_e             head;
  logic             full, accept, pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTST - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full = (outst_cnt == 3'(MAX_OUTST));

  // An issued-but-unaccepted request keeps the grant so its address and
  // data cannot change under the memory while it is deciding.
  assign grant  = lock_vld ? lock_src : (data_req ? SRC_DATA : SRC_INST);
  assign mem_req = resetn & ~full & (inst_req | data_req);

  assign mem_wr    = (grant == SRC_DATA) ? data_wr    : inst_wr;
  assign mem_wstrb = (grant == SRC_DATA) ? data_wstrb : inst_wstrb;
  assign mem_addr  = (grant == SRC_DATA) ? data_addr  : inst_addr;
  assign mem_wdata = (grant == SRC_DATA) ? data_wdata : inst_wdata;

  assign accept       = mem_req & mem_addr_ok;
  assign inst_addr_ok = accept & (grant == SRC_INST);
  assign data_addr_ok = accept & (grant == SRC_DATA);

  assign head         = src_fifo[rd_ptr];
  assign pop          = resetn & mem_data_ok & (outst_cnt != 3'd0);
  assign inst_data_ok = pop & (head == SRC_INST);
  assign data_data_ok = pop & (head == SRC_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      outst_cnt <= 3'd0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      lock_vld  <= 1'b0;
      lock_src  <= SRC_INST;
    end else begin
      if (accept) wr_ptr <= next_ptr(wr_ptr);
      if (pop)    rd_ptr <= next_ptr(rd_ptr);

      case ({accept, pop})
        2'b10:   outst_cnt <= outst_cnt + 3'd1;
        2'b01:   outst_cnt <= outst_cnt - 3'd1;
        default: outst_cnt <= outst_cnt;
      endcase

      if (accept) begin
        lock_vld <= 1'b0;
      end else if (mem_req) begin
        lock_vld <= 1'b1;
        lock_src <= grant;
      end
    end
  end

  // NOTE: FIFO storage has no reset; an entry is only read after it was
  // written, and the pointers/count that qualify it are reset.
  always_ff @(posedge clk) begin
    if (accept) src_fifo[wr_ptr] <= grant;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: stimulus pushes expected handshake
// events into a queue, a negedge monitor pops and compares DUT pulses.
module tb_mem_port_arbiter;

  localparam logic [31:0] I_ADDR  = 32'h0000_1000;
  localparam logic [31:0] I_WDATA = 32'h1111_1111;
  localparam logic [31:0] D_ADDR  = 32'h0000_2000;
  localparam logic [31:0] D_WDATA = 32'h2222_2222;

  typedef enum logic [1:0] {EV_IA, EV_DA, EV_ID, EV_DD} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    logic [31:0] rdata;
  } ev_t;

  logic        clk, resetn;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [3:0]  inst_wstrb, data_wstrb;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  outst_cnt;

  int  total = 0;
  int  bad   = 0;
  ev_t exp_q[$];

  mem_port_arbiter #(.MAX_OUTST(2)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_wstrb(inst_wstrb),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .outst_cnt(outst_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input ev_kind_e kind, input logic [31:0] rdata);
    ev_t e;
    e.kind  = kind;
    e.rdata = rdata;
    exp_q.push_back(e);
  endtask

  task automatic take(input ev_kind_e kind, input logic [31:0] rdata);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event: got kind %0d rdata %h expected none", kind, rdata);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.rdata !== rdata) begin
        bad++;
        $display("FAIL event: got kind %0d rdata %h expected kind %0d rdata %h",
                 kind, rdata, e.kind, e.rdata);
      end
    end
  endtask

  // Monitor: every handshake pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (inst_addr_ok) take(EV_IA, 32'h0);
    if (data_addr_ok) take(EV_DA, 32'h0);
    if (inst_data_ok) take(EV_ID, inst_rdata);
    if (data_data_ok) take(EV_DD, data_rdata);
  end

  task automatic apply(input logic ir, input logic dr, input logic aok,
                       input logic dok, input logic [31:0] rd);
    @(posedge clk);
    #1;
    inst_req    = ir;
    data_req    = dr;
    mem_addr_ok = aok;
    mem_data_ok = dok;
    mem_rdata   = rd;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    resetn      = 1'b0;
    inst_req    = 1'b1;
    data_req    = 1'b0;
    inst_wr     = 1'b0;
    inst_wstrb  = 4'h0;
    inst_addr   = I_ADDR;
    inst_wdata  = I_WDATA;
    data_wr     = 1'b1;
    data_wstrb  = 4'hf;
    data_addr   = D_ADDR;
    data_wdata  = D_WDATA;
    mem_addr_ok = 1'b1;
    mem_data_ok = 1'b0;
    mem_rdata   = 32'h0;

    sample();
    check("reset_cnt", 32'(outst_cnt), 32'd0);
    check("reset_mem_req", 32'(mem_req), 32'd0);
    @(posedge clk);
    #1;
    resetn   = 1'b1;
    inst_req = 1'b0;

    // Simultaneous requests: data wins, then inst next cycle.
    apply(1, 1, 1, 0, 32'h0);
    expect_ev(EV_DA, 32'h0);
    sample();
    check("prio_mem_req", 32'(mem_req), 32'd1);
    check("prio_mem_addr", mem_addr, D_ADDR);
    check("prio_mem_wr", 32'(mem_wr), 32'd1);
    check("prio_mem_wdata", mem_wdata, D_WDATA);
    apply(1, 0, 1, 0, 32'h0);
    expect_ev(EV_IA, 32'h0);
    sample();
    check("next_inst_addr", mem_addr, I_ADDR);
    check("next_inst_wr", 32'(mem_wr), 32'd0);
    apply(1, 1, 1, 0, 32'h0);
    sample();
    check("full_cnt", 32'(outst_cnt), 32'd2);
    check("full_mem_req", 32'(mem_req), 32'd0);
    apply(0, 0, 0, 1, 32'hAAAA_0001);
    expect_ev(EV_DD, 32'hAAAA_0001);
    sample();
    apply(0, 0, 0, 1, 32'hBBBB_0002);
    expect_ev(EV_ID, 32'hBBBB_0002);
    sample();
    apply(0, 0, 0, 0, 32'h0);
    sample();
    check("drain_cnt", 32'(outst_cnt), 32'd0);

    // Stalled inst request keeps the grant when data rises.
    apply(1, 0, 0, 0, 32'h0);
    sample();
    check("lock_c1_addr", mem_addr, I_ADDR);
    apply(1, 1, 0, 0, 32'h0);
    sample();
    check("lock_c2_addr", mem_addr, I_ADDR);
    apply(1, 1, 0, 0, 32'h0);
    sample();
    check("lock_c3_addr", mem_addr, I_ADDR);
    apply(1, 1, 1, 0, 32'h0);
    expect_ev(EV_IA, 32'h0);
    sample();
    check("lock_acc_addr", mem_addr, I_ADDR);
    apply(0, 1, 1, 0, 32'h0);
    expect_ev(EV_DA, 32'h0);
    sample();
    check("after_lock_addr", mem_addr, D_ADDR);

    // Full with inst,data outstanding: third request blocked; response to inst.
    apply(1, 0, 0, 0, 32'h0);
    sample();
    check("full2_mem_req", 32'(mem_req), 32'd0);
    check("full2_cnt", 32'(outst_cnt), 32'd2);
    check("full2_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
    apply(0, 0, 0, 1, 32'h0000_1234);
    expect_ev(EV_ID, 32'h0000_1234);
    sample();
    check("rsp_inst_rdata", inst_rdata, 32'h0000_1234);
    // Accept and response on the same edge: count holds, old head (data) routed.
    apply(1, 0, 1, 1, 32'h0000_5678);
    expect_ev(EV_IA, 32'h0);
    expect_ev(EV_DD, 32'h0000_5678);
    sample();
    check("same_edge_pre_cnt", 32'(outst_cnt), 32'd1);
    apply(0, 0, 0, 0, 32'h0);
    sample();
    check("same_edge_cnt", 32'(outst_cnt), 32'd1);
    apply(0, 0, 0, 1, 32'h0000_9ABC);
    expect_ev(EV_ID, 32'h0000_9ABC);
    sample();

    // Spurious response while empty.
    apply(0, 0, 0, 1, 32'h0000_DEAD);
    sample();
    check("empty_cnt", 32'(outst_cnt), 32'd0);
    check("empty_data_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
    apply(0, 0, 0, 0, 32'h0);
    sample();
    check("empty_cnt_after", 32'(outst_cnt), 32'd0);

    // Fill, then asynchronous reset mid-cycle.
    apply(1, 0, 1, 0, 32'h0);
    expect_ev(EV_IA, 32'h0);
    apply(0, 1, 1, 0, 32'h0);
    expect_ev(EV_DA, 32'h0);
    apply(1, 1, 0, 0, 32'h0);
    sample();
    check("pre_rst_cnt", 32'(outst_cnt), 32'd2);
    #2;
    resetn = 1'b0;
    #1;
    check("async_rst_cnt", 32'(outst_cnt), 32'd0);
    check("async_rst_mem_req", 32'(mem_req), 32'd0);
    mem_data_ok = 1'b1;
    #1;
    check("rst_data_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
    check("rst_addr_ok", 32'({inst_addr_ok, data_addr_ok}), 32'd0);
    @(posedge clk);
    #1;
    check("rst_hold_cnt", 32'(outst_cnt), 32'd0);

    // First grant on the first edge after release.
    @(posedge clk);
    #1;
    resetn      = 1'b1;
    mem_data_ok = 1'b0;
    mem_addr_ok = 1'b1;
    expect_ev(EV_DA, 32'h0);
    sample();
    check("post_rst_addr", mem_addr, D_ADDR);
    apply(0, 0, 0, 0, 32'h0);
    sample();
    check("post_rst_cnt", 32'(outst_cnt), 32'd1);
    apply(0, 0, 0, 1, 32'h0F0F_0F0F);
    expect_ev(EV_DD, 32'h0F0F_0F0F);
    sample();
    apply(0, 0, 0, 0, 32'h0);
    sample();
    check("final_cnt", 32'(outst_cnt), 32'd0);

    @(posedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
